seg7_scan: RTL and testbench

Multiplexed 4-digit seven-segment display driver for the lab boards. It consumes the count or status values that the board's counters produce and drives a common-anode display. Each capture loads the digits into a shadow register on a `load` strobe. The block then scans one digit at a time at a divided refresh rate, with an all-off gap between digits to prevent ghosting. It sits between any value-producing block (counters, FSM state) and the board's anode/segment pins.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/hex7seg.sv | 19 +
 rtl/seg7_scan.sv | 145 ++++++++++++++
 tb/tb_seg7_scan.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and constants for the seg7_scan display driver.
//            - seg7_state_t : scan state (GAP = all-off, DRIVE = digit lit)
//            - c_SEG_TABLE  : hex nibble -> active-low {g,f,e,d,c,b,a}
//            - seg7_div()   : clocks per digit slot (CLK_HZ / SCAN_HZ)
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [0:0] {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } seg7_state_t;

    // Packed so index 0 is the rightmost entry of the concatenation.
    localparam logic [15:0][6:0] c_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic int seg7_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational hex nibble to seven-segment decoder, active-low.
// Ports    : nibble [3:0] in  - hex digit
//            seg    [6:0] out - {g,f,e,d,c,b,a}, 0 = segment lit
// Revision : 1.0  initial release
// ============================================================================
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = c_SEG_TABLE[nibble];

endmodule : hex7seg
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : Multiplexed 4-digit common-anode seven-segment driver. A load
//            strobe captures value/dp into a shadow register; digits are then
//            scanned 0,1,2,3 with an all-off gap at the start of every slot.
// Ports    : clk           in  - clock
//            rst           in  - asynchronous active-high reset
//            value [15:0]  in  - four hex digits, digit 0 in [3:0]
//            dp    [3:0]   in  - decimal point per digit, 1 = lit
//            load          in  - capture value/dp into the shadow register
//            blank_lz      in  - live leading-zero blanking enable
//            an    [3:0]   out - anode enables, active-low
//            seg   [6:0]   out - segments {g,f,e,d,c,b,a}, active-low
//            dp_n          out - decimal point, active-low
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int GAP_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam int c_DIV       = seg7_div(CLK_HZ, SCAN_HZ);
    localparam int c_DRIVE_CYC = c_DIV - GAP_CYC;
    // Enough bits to count to DIV-1, which bounds both state lengths.
    localparam int c_CNT_W     = (c_DIV > 2) ? $clog2(c_DIV) : 1;

    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_DRIVE_LAST = c_CNT_W'(c_DRIVE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    seg7_state_t        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic [15:0]        r_shadow_val;
    logic [3:0]         r_shadow_dp;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp_n;

    logic [3:0]         w_nib_zero;
    logic [3:0]         w_upper_zero;
    logic [3:0]         w_nibble;
    logic [6:0]         w_dec_seg;
    logic               w_blank;
    logic [3:0]         w_drive_an;

    // ------------------------------------------------------------------
    // Shadow register: the scan always reads a coherent captured word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'h0;
        end else if (load) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection: w_upper_zero[k] means nibbles k..3 are zero.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_lz
        assign w_nib_zero[k]   = (r_shadow_val[4*k +: 4] == 4'h0);
        assign w_upper_zero[k] = &w_nib_zero[3:k];
    end

    // Digit 0 always shows, so a value of zero still reads "0".
    assign w_blank    = blank_lz && (r_idx != 2'd0) && w_upper_zero[r_idx];
    assign w_nibble   = r_shadow_val[{r_idx, 2'b00} +: 4];
    assign w_drive_an = ~(4'b0001 << r_idx);

    hex7seg u_hex7seg (
        .nibble (w_nibble),
        .seg    (w_dec_seg)
    );

    // ------------------------------------------------------------------
    // Slot divider / scan FSM with registered pin drivers. Outputs are
    // derived from the state before the edge, so they lag it by one clock.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= GAP;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_an    <= 4'hF;
            r_seg   <= 7'h7F;
            r_dp_n  <= 1'b1;
        end else begin
            case (r_state)
                GAP: begin
                    r_an   <= 4'hF;
                    r_seg  <= 7'h7F;
                    r_dp_n <= 1'b1;
                    if (r_cnt == c_GAP_LAST) begin
                        r_state <= DRIVE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                DRIVE: begin
                    r_an   <= w_drive_an;
                    r_seg  <= w_blank ? 7'h7F : w_dec_seg;
                    r_dp_n <= ~r_shadow_dp[r_idx];
                    if (r_cnt == c_DRIVE_LAST) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= GAP;
                    r_cnt   <= '0;
                    r_an    <= 4'hF;
                    r_seg   <= 7'h7F;
                    r_dp_n  <= 1'b1;
                end
            endcase
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp_n = r_dp_n;

endmodule : seg7_scan
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Self-checking bench for seg7_scan. A time-based reference model
//            (slot position from the edge count since reset) predicts every
//            output word; table vectors and hand sequences cover decode,
//            blanking, mid-drive loads, async reset and gap integrity.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan;

    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 100;
    localparam int GAP_CYC = 2;
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int SCAN    = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    seg7_scan #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dp       (dp),
        .load     (load),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          edges = 0;
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dp  = 4'h0;
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [6:0] ref_tbl [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [15:0]     v;
        logic [3:0]      d;
        logic            b;
        logic [3:0][6:0] s;   // expected seg for digit 3..0
    } vec_t;

    vec_t vecs [6];

    // Expected {an, seg, dp_n} for the scan state reached after m edges.
    function automatic logic [11:0] model_out(input int m, input logic [15:0] v,
                                              input logic [3:0] d, input logic blz);
        int          pos;
        int          dig;
        logic [15:0] sh;
        logic [6:0]  s;
        logic [3:0]  a;
        pos = m % DIV;
        dig = (m / DIV) % 4;
        if (pos < GAP_CYC) return 12'hFFF;
        sh = v >> (4 * dig);
        s  = ref_tbl[sh[3:0]];
        if (blz && dig != 0 && sh == 16'h0000) s = 7'h7F;
        a = ~(4'b0001 << dig);
        return {a, s, ~d[dig]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: predict, advance the model, step the DUT, compare.
    task automatic tick();
        logic [11:0] e;
        e = model_out(edges, m_val, m_dp, blank_lz);
        if (load) begin
            m_val = value;
            m_dp  = dp;
        end
        edges++;
        @(posedge clk);
        #1;
        chk("model", {4'h0, an, seg, dp_n}, {4'h0, e});
    endtask

    // Advance until the outputs show scan position 'target' (0..SCAN-1).
    task automatic goto_pos(input int target);
        for (int i = 0; i < 2 * SCAN && ((edges - 1) % SCAN) != target; i++) tick();
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] d, input logic b);
        value    = v;
        dp       = d;
        blank_lz = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic model_reset();
        edges = 0;
        m_val = 16'h0000;
        m_dp  = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         gap_run;
        int         seen_low;
        logic [3:0] last_low;
        logic [3:0] exp_an;

        vecs[0] = '{16'hA5F0, 4'b0100, 1'b0, {7'b0001000, 7'b0010010, 7'b0001110, 7'b1000000}};
        vecs[1] = '{16'h0030, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[3] = '{16'h8E00, 4'b0000, 1'b1, {7'b0000000, 7'b0000110, 7'b1000000, 7'b1000000}};
        vecs[4] = '{16'h7BD6, 4'b1010, 1'b0, {7'b1111000, 7'b0000011, 7'b0100001, 7'b0000010}};
        vecs[5] = '{16'h0001, 4'b1000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001}};

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_state", {4'h0, an, seg, dp_n}, 16'h0FFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset then idle: 2 gap clocks, digit0 for 8, gap 2, then digit1
        for (int n = 1; n <= 13; n++) begin
            tick();
            exp_an = (n >= 3 && n <= 10) ? 4'hE : (n == 13) ? 4'hD : 4'hF;
            chk($sformatf("idle_an_%0d", n), {12'h0, an}, {12'h0, exp_an});
        end

        // Table-driven decode / blanking vectors
        for (int i = 0; i < 6; i++) begin
            load_word(vecs[i].v, vecs[i].d, vecs[i].b);
            for (int dig = 0; dig < 4; dig++) begin
                goto_pos(dig * DIV + GAP_CYC + 3);
                chk($sformatf("vec%0d_d%0d", i, dig), {4'h0, an, seg, dp_n},
                    {4'h0, ~(4'b0001 << dig), vecs[i].s[dig], ~vecs[i].d[dig]});
            end
        end

        // Mid-drive load during digit0
        load_word(16'h0000, 4'h0, 1'b0);
        goto_pos(GAP_CYC + 3);
        value = 16'h0009;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk("middrive_old", {5'h0, an, seg}, {5'h0, 4'hE, 7'b1000000});
        tick();
        chk("middrive_new", {5'h0, an, seg}, {5'h0, 4'hE, 7'b0010000});

        // Asynchronous reset during digit2 drive
        load_word(16'h5555, 4'hF, 1'b0);
        goto_pos(2 * DIV + GAP_CYC + 3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {4'h0, an, seg, dp_n}, 16'h0FFF);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_held", {4'h0, an, seg, dp_n}, 16'h0FFF);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_gap1", {12'h0, an}, 16'h000F);
        tick();
        chk("rst_gap2", {12'h0, an}, 16'h000F);
        tick();
        chk("rst_restart", {4'h0, an, seg, dp_n}, {4'h0, 4'hE, 7'b1000000, 1'b1});

        // Randomized run with gap-integrity monitoring
        gap_run  = 0;
        seen_low = 0;
        last_low = 4'hF;
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 3) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            tick();
            chk("an_onehot", {15'h0, ($countones(~an) <= 1)}, 16'h0001);
            if (an == 4'hF) begin
                gap_run++;
            end else begin
                if (seen_low != 0 && an != last_low)
                    chk("gap_len", 16'(gap_run), 16'd2);
                seen_low = 1;
                last_low = an;
                gap_run  = 0;
            end
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seg7_scan
`default_nettype wire
